fib_seq_engine: RTL
===================

Name: fib_seq_engine

Overview:
Parametrised successor to the team's 16-bit Fibonacci block. Computes the n-th term of a generalised two-term additive recurrence x(k+2) = x(k+1) + x(k), with three seed modes: Fibonacci, Lucas, or custom seeds. Adds configurable width, overflow detection, and wrap or saturate arithmetic. Sits as a start/done-handshaked compute slave behind the same control logic as the existing block.

Parameters:
WIDTH, 32, data/result width in bits (>= 4)
N_WIDTH, 16, width of the term index input
SATURATE, 0, 0 = results wrap modulo 2^WIDTH; 1 = results clamp to all-ones once overflow occurs

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level request; sampled only in IDLE
din  input  N_WIDTH  term index n (unsigned)
mode  input  2  00 Fibonacci (seeds 0,1); 01 Lucas (seeds 2,1); 10 custom (seed_a, seed_b); 11 reserved, treated as 00
seed_a  input  WIDTH  custom x(0), used when mode=10
seed_b  input  WIDTH  custom x(1), used when mode=10
dout  output  WIDTH  x(n), registered
done  output  1  result valid, registered
busy  output  1  high while in COMPUTE (decoded from the state register)
overflow  output  1  some addition for the current result carried out of WIDTH bits; registered with dout

Behaviour:
- Reset values (reset high at any clock edge, including mid-COMPUTE or in DONE):
  - state = IDLE.
  - dout, done, overflow, busy, internal a/b/count/ovf = 0.
  - An in-flight computation is discarded and no done is produced.
- Internal registers: a = x(k), b = x(k+1), count (N_WIDTH), sticky ovf.
- Inputs din, mode, seed_a and seed_b are sampled only at the IDLE edge where start=1. Later changes have no effect on the current job.
- IDLE:
  - done=0. dout and overflow hold their previous values.
  - If start=1: load a=s0, b=s1, count=n-1, ovf=0.
  - n=0: go to DONE; dout<=s0, overflow<=0, done<=1 on the same edge.
  - n=1: go to DONE; dout<=s1, overflow<=0, done<=1 on the same edge.
  - n>=2: go to COMPUTE.
- COMPUTE:
  - Each cycle: a<=b; b<=a+b (WIDTH+1-bit sum, lower WIDTH bits kept); count<=count-1; ovf<=ovf | carry.
  - On the cycle with count==1, go to DONE, with done<=1 on the same edge.
    - dout<=sum, or all-ones if SATURATE=1 and (ovf|carry).
    - overflow<=ovf|carry.
  - start is ignored while in COMPUTE.
- Latency, counted from the start-sampling edge to done=1: 1 cycle for n<=2, n-1 cycles for n>=2. Exactly n-1 additions are performed.
- DONE:
  - done=1; dout and overflow are stable.
  - Stays in DONE while start=1, with no retrigger.
  - When start=0 is sampled: go to IDLE and done<=0 on that edge.
  - A new job needs start to be seen low for at least one edge.
- Overflow is sticky per job and cleared at each new start.
  - With wrap arithmetic (SATURATE=0), dout is the exact value modulo 2^WIDTH.
  - With SATURATE=1, any overflow anywhere in the chain forces dout = all-ones, including overflow caused by large custom seeds.
- n=0 and n=1 never set overflow, even if the seeds are large.
- Maximum n is 2^N_WIDTH-1. count never underflows because COMPUTE exits when count==1.

Test Plan:
- WIDTH=16, mode=00, din=10, start held high:
  - done rises 9 cycles after the start edge with dout=55, overflow=0, busy=1 for 9 cycles.
  - Dropping start returns to IDLE, done=0, and dout holds 55.
- WIDTH=16, mode=00: din=0 gives dout=0; din=1 gives dout=1; din=2 gives dout=1. All three show done 1 cycle after start, busy never high for n<=1.
- Boundary, WIDTH=16, mode=00:
  - din=24 gives 46368, overflow=0.
  - din=25 with SATURATE=0 gives 9489 (75025 mod 65536), overflow=1.
  - din=25 with SATURATE=1 gives 65535, overflow=1.
- Modes:
  - mode=01, din=10 gives 123.
  - mode=10, seed_a=3, seed_b=4, din=5 gives 29.
  - mode=10, seed_a=seed_b=0xFFFF (WIDTH=16), din=2 gives overflow=1.
- Reset and stability:
  - Assert reset during COMPUTE of din=20: next edge state=IDLE, all outputs 0, no done.
  - Change din/mode mid-COMPUTE: result is unaffected.
  - Hold start high in DONE: no restart, done stays 1.

Source files
------------

// File: rtl/fib_seq_engine.sv
// Two-term additive recurrence engine (Fibonacci / Lucas / custom seeds) with wrap or saturate.
// Latency: done one edge after start for n<=1, n-1 edges after start for n>=2.
// Backpressure: done holds until start is seen low; start is ignored while busy.
module fib_seq_engine #(
    parameter int WIDTH    = 32,
    parameter int N_WIDTH  = 16,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [N_WIDTH-1:0] din,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   seed_a,
    input  logic [WIDTH-1:0]   seed_b,
    output logic [WIDTH-1:0]   dout,
    output logic               done,
    output logic               busy,
    output logic               overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a, b;
    logic [N_WIDTH-1:0] count;
    logic               ovf;
    logic [WIDTH-1:0]   s0, s1;
    logic [WIDTH:0]     sum;
    logic               carry;
    logic               ovf_any;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign carry   = sum[WIDTH];
    assign ovf_any = ovf | carry;
    assign busy    = (state == COMPUTE);

    // Reserved mode 11 falls back to Fibonacci seeds.
    always_comb begin
        s0 = '0;
        s1 = WIDTH'(1);
        case (mode)
            2'b01: begin
                s0 = WIDTH'(2);
                s1 = WIDTH'(1);
            end
            2'b10: begin
                s0 = seed_a;
                s1 = seed_b;
            end
            default: begin
                s0 = '0;
                s1 = WIDTH'(1);
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (din < N_WIDTH'(2)) state_nxt = DONE;
                    else                   state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                if (count == N_WIDTH'(1)) state_nxt = DONE;
            end
            DONE: begin
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            dout     <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a     <= s0;
                        b     <= s1;
                        count <= din - N_WIDTH'(1);
                        ovf   <= 1'b0;
                        // Trivial indices bypass COMPUTE and never flag overflow.
                        if (din == '0) begin
                            dout     <= s0;
                            overflow <= 1'b0;
                            done     <= 1'b1;
                        end else if (din == N_WIDTH'(1)) begin
                            dout     <= s1;
                            overflow <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    a     <= b;
                    b     <= sum[WIDTH-1:0];
                    count <= count - N_WIDTH'(1);
                    ovf   <= ovf_any;
                    if (count == N_WIDTH'(1)) begin
                        done     <= 1'b1;
                        overflow <= ovf_any;
                        dout     <= ((SATURATE != 0) && ovf_any) ? '1 : sum[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (!start) done <= 1'b0;
                end
                default: done <= 1'b0;
            endcase
        end
    end

endmodule
